sqr_chain_ctrl: RTL

- Sequencer for the combinational GF(2^233) squarer (field polynomial x^233 + x^74 + 1).
- Computes A^(2^N) by iterating the squarer N times over a single 233-bit working register.
- Serves the Itoh-Tsujii inversion and point-arithmetic control, which issue repeated-squaring jobs through a start/done handshake.
- One squarer instance is the default; a second cascaded instance is optional.

---
 rtl/sqr_chain_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sqr_chain_ctrl.sv
// Repeated-squaring sequencer over GF(2^233), field polynomial x^233 + x^74 + 1.
// Define SQR_DOUBLE_EN to cascade two squarers and retire up to two squarings per cycle.
module sqr_chain_ctrl #(
  parameter int M     = 233,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_nsq,
  input  logic [M-1:0]     i_din,
  output logic             o_busy,
  output logic             o_done,
  output logic [M-1:0]     o_dout
);

  localparam int PW = 2 * M - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [M-1:0]     r_work;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [M-1:0]     w_sq1;

  // Spread the bits to even positions, then fold every term of degree >= 233
  // back down using x^233 = x^74 + 1, highest degree first so folded terms
  // that still land above 232 are folded again.
  function automatic logic [M-1:0] gf_sqr(input logic [M-1:0] a);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < M; i++) begin
      c[2*i] = a[i];
    end
    for (int k = PW - 1; k >= M; k--) begin
      if (c[k]) begin
        c[k-M+74] = ~c[k-M+74];
        c[k-M]    = ~c[k-M];
        c[k]      = 1'b0;
      end
    end
    return c[M-1:0];
  endfunction

  assign w_sq1 = gf_sqr(r_work);

`ifdef SQR_DOUBLE_EN
  logic [M-1:0] w_sq2;
  assign w_sq2 = gf_sqr(w_sq1);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_work <= i_din;
            r_cnt  <= i_nsq;
            if (i_nsq == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_RUN: begin
`ifdef SQR_DOUBLE_EN
          if (r_cnt >= CNT_W'(2)) begin
            r_work <= w_sq2;
            r_cnt  <= r_cnt - CNT_W'(2);
            if (r_cnt == CNT_W'(2)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            // Odd remainder: finish with a single squaring.
            r_work  <= w_sq1;
            r_cnt   <= '0;
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
`else
          r_work <= w_sq1;
          r_cnt  <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
`endif
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_dout = r_work;

endmodule
